// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - byte-addressed data memory with a RISC-V load/store unit
// One request in flight: IDLE accepts, BUSY counts wait states then accesses, RESP holds the result.
module data_mem_lsu #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 15,
  parameter int WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o
);

  localparam int LANES = XLEN / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

  state_e            state_q;
  logic [7:0]        cnt_q;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;

  logic [XLEN-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic [OFF_W-1:0]  off;
  logic [LANES-1:0]  size_mask;
  logic [LANES-1:0]  be;
  logic [XLEN-1:0]   wdata_sh;
  logic [XLEN-1:0]   rd_word;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   up;
  logic [XLEN-1:0]   zx;
  logic signed [XLEN-1:0] sx;
  logic [6:0]        trim;
  logic [XLEN-1:0]   load_val;
  logic              illegal;
  logic              misaligned;
  logic              out_of_range;
  logic              err_d;
  logic              access;
  logic              do_write;

  always_comb begin
    idx      = addr_q[ADDR_W+OFF_W-1:OFF_W];
    off      = addr_q[OFF_W-1:0];
    wdata_sh = wdata_q << {off, 3'b000};
    rd_word  = mem[idx];
    shifted  = rd_word >> {off, 3'b000};

    size_mask = LANES'(8'h01);
    trim      = 7'(XLEN - 8);
    case (funct3_q[1:0])
      2'b00: begin size_mask = LANES'(8'h01); trim = 7'(XLEN - 8);  end
      2'b01: begin size_mask = LANES'(8'h03); trim = 7'(XLEN - 16); end
      2'b10: begin size_mask = LANES'(8'h0F); trim = 7'(XLEN - 32); end
      default: begin size_mask = LANES'(8'hFF); trim = 7'd0; end
    endcase
    be = size_mask << off;

    // Left-justify the field, then shift back to truncate and extend in one step
    up       = shifted << trim;
    zx       = up >> trim;
    sx       = $signed(up) >>> trim;
    load_val = funct3_q[2] ? zx : sx;

    illegal = (we_q & funct3_q[2]) | (funct3_q == 3'b111) |
              ((XLEN == 32) & ((funct3_q == 3'b011) | (funct3_q == 3'b110)));
    case (funct3_q[1:0])
      2'b01:   misaligned = addr_q[0];
      2'b10:   misaligned = |addr_q[1:0];
      2'b11:   misaligned = |addr_q[2:0];
      default: misaligned = 1'b0;
    endcase
    out_of_range = |(addr_q >> (ADDR_W + OFF_W));
    err_d        = illegal | misaligned | out_of_range;

    access   = (state_q == S_BUSY) && (cnt_q == 8'd0);
    do_write = access && we_q && !err_d;
  end

  // Array has no reset so a mid-operation reset cannot disturb stored data
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int k = 0; k < LANES; k++) begin
        if (be[k]) mem[idx][8*k +: 8] <= wdata_sh[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            we_q     <= req_we_i;
            funct3_q <= req_funct3_i;
            addr_q   <= req_addr_i;
            wdata_q  <= req_wdata_i;
            cnt_q    <= 8'(WAIT_STATES);
            rdata_q  <= '0;
            err_q    <= 1'b0;
            state_q  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt_q == 8'd0) begin
            err_q   <= err_d;
            rdata_q <= (err_d || we_q) ? '0 : load_val;
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - self-checking bench for data_mem_lsu
// Three instances: XLEN32/WS0, XLEN32/WS3, XLEN64/WS2, checked against a byte-addressed model.
module tb_data_mem_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  req_valid, req_ready, rsp_valid, rsp_err;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_ready;
  logic [31:0] rd0, rd1;
  logic [63:0] rd2;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] mm [longint];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [63:0] exp;
  } op_t;

  data_mem_lsu #(.XLEN(32), .ADDR_W(15), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr[31:0]), .req_wdata_i(req_wdata[31:0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rd0), .rsp_err_o(rsp_err[0]));

  data_mem_lsu #(.XLEN(32), .ADDR_W(15), .WAIT_STATES(3)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr[31:0]), .req_wdata_i(req_wdata[31:0]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rd1), .rsp_err_o(rsp_err[1]));

  data_mem_lsu #(.XLEN(64), .ADDR_W(10), .WAIT_STATES(2)) u2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid[2]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rd2), .rsp_err_o(rsp_err[2]));

  function automatic logic [63:0] rdata_of(input int d);
    case (d)
      0:       return {32'b0, rd0};
      1:       return {32'b0, rd1};
      default: return rd2;
    endcase
  endfunction

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : 2;
  endfunction

  // Byte-level model: memory is just bytes keyed by instance and byte address
  function automatic void model_op(input int d, input logic we, input logic [2:0] f3,
                                   input logic [63:0] addr, input logic [63:0] wd,
                                   output logic [63:0] rd, output logic err);
    int          xlen;
    int          abits;
    int          sz;
    longint      k;
    logic [63:0] v;
    logic        ill, mis, oor;
    xlen  = (d == 2) ? 64 : 32;
    abits = (d == 2) ? 13 : 17;
    sz    = 1 << f3[1:0];
    ill = (we && f3[2]) || (f3 == 3'b111) || (xlen == 32 && (f3 == 3'b011 || f3 == 3'b110));
    mis = (addr % 64'(sz)) != 0;
    oor = (addr >> abits) != 0;
    err = ill || mis || oor;
    rd  = '0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < sz; i++) begin
        k = (longint'(d) << 40) + longint'(addr) + i;
        mm[k] = wd[8*i +: 8];
      end
      return;
    end
    v = '0;
    for (int i = 0; i < sz; i++) begin
      k = (longint'(d) << 40) + longint'(addr) + i;
      v[8*i +: 8] = mm.exists(k) ? mm[k] : 8'h00;
    end
    if (!f3[2] && sz * 8 < xlen && v[sz*8-1]) v = v | (~64'b0 << (sz * 8));
    if (xlen == 32) v[63:32] = '0;
    rd = v;
  endfunction

  task automatic do_op(input int d, input logic we, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wd, input int hold,
                       output logic [63:0] rd, output logic err, output int lat, output bit to);
    int n;
    to = 0; rd = '0; err = 1'b0; lat = 0;
    @(negedge clk);
    n = 0;
    while (!req_ready[d] && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin to = 1; return; end
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    req_valid = 3'b0; req_valid[d] = 1'b1;
    @(posedge clk); #1;
    req_valid = 3'b0;
    while (!rsp_valid[d] && lat < 300) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid[d]) begin to = 1; return; end
    repeat (hold) begin @(posedge clk); #1; end
    rd  = rdata_of(d);
    err = rsp_err[d];
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 3'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_err[d] !== 1'b0 || rdata_of(d) !== 64'h0) begin
        n_fail++;
        $display("FAIL reset[%0d]: rdy=%b vld=%b err=%b rdata=%h, required rdy=1 vld=0 err=0 rdata=0",
                 d, req_ready[d], rsp_valid[d], rsp_err[d], rdata_of(d));
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic prefill();
    logic [63:0] rd, m;
    logic e, me;
    int lat;
    bit to;
    for (int d = 0; d < 3; d++) begin
      for (int a = 0; a < 128; a += (d == 2 ? 8 : 4)) begin
        do_op(d, 1'b1, (d == 2) ? 3'b011 : 3'b010, 64'(a), 64'h0, 0, rd, e, lat, to);
        model_op(d, 1'b1, (d == 2) ? 3'b011 : 3'b010, 64'(a), 64'h0, m, me);
        if (to) begin
          n_cmp++; n_fail++;
          $display("FAIL prefill[%0d] timeout at addr %0h", d, a);
        end
      end
    end
  endtask

  task automatic test_basic();
    op_t t[$];
    logic [63:0] rd, m;
    logic e, me;
    int lat;
    bit to;
    t.push_back('{1'b1, 3'b010, 64'h10, 64'h8899AABB, 64'h0});
    t.push_back('{1'b0, 3'b010, 64'h10, 64'h0, 64'h8899AABB});
    t.push_back('{1'b0, 3'b000, 64'h13, 64'h0, 64'hFFFFFF88});
    t.push_back('{1'b0, 3'b100, 64'h13, 64'h0, 64'h00000088});
    t.push_back('{1'b0, 3'b001, 64'h10, 64'h0, 64'hFFFFAABB});
    t.push_back('{1'b0, 3'b101, 64'h12, 64'h0, 64'h00008899});
    t.push_back('{1'b1, 3'b000, 64'h11, 64'h123456CC, 64'h0});
    t.push_back('{1'b0, 3'b010, 64'h10, 64'h0, 64'h8899CCBB});
    t.push_back('{1'b1, 3'b001, 64'h12, 64'h7777, 64'h0});
    t.push_back('{1'b0, 3'b010, 64'h10, 64'h0, 64'h7777CCBB});
    foreach (t[i]) begin
      do_op(0, t[i].we, t[i].f3, t[i].addr, t[i].wd, 0, rd, e, lat, to);
      model_op(0, t[i].we, t[i].f3, t[i].addr, t[i].wd, m, me);
      n_cmp++;
      if (to || rd !== t[i].exp || e !== 1'b0 || lat != 1) begin
        n_fail++;
        $display("FAIL basic[%0d]: rdata=%h err=%b lat=%0d to=%0d, required rdata=%h err=0 lat=1",
                 i, rd, e, lat, to, t[i].exp);
      end
    end
  endtask

  task automatic test_errors();
    op_t t[$];
    logic [63:0] rd, m;
    logic e, me;
    int lat;
    bit to;
    t.push_back('{1'b0, 3'b001, 64'h11, 64'h0, 64'h0});
    t.push_back('{1'b0, 3'b010, 64'h12, 64'h0, 64'h0});
    t.push_back('{1'b0, 3'b111, 64'h10, 64'h0, 64'h0});
    t.push_back('{1'b1, 3'b010, 64'h20010, 64'hFFFFFFFF, 64'h0});
    t.push_back('{1'b1, 3'b100, 64'h10, 64'h55, 64'h0});
    t.push_back('{1'b0, 3'b011, 64'h10, 64'h0, 64'h0});
    t.push_back('{1'b0, 3'b110, 64'h10, 64'h0, 64'h0});
    foreach (t[i]) begin
      do_op(0, t[i].we, t[i].f3, t[i].addr, t[i].wd, 0, rd, e, lat, to);
      model_op(0, t[i].we, t[i].f3, t[i].addr, t[i].wd, m, me);
      n_cmp++;
      if (to || rd !== 64'h0 || e !== 1'b1 || lat != 1) begin
        n_fail++;
        $display("FAIL error[%0d]: rdata=%h err=%b lat=%0d to=%0d, required rdata=0 err=1 lat=1",
                 i, rd, e, lat, to);
      end
    end
    do_op(0, 1'b0, 3'b010, 64'h10, 64'h0, 0, rd, e, lat, to);
    n_cmp++;
    if (to || rd !== 64'h7777CCBB || e !== 1'b0) begin
      n_fail++;
      $display("FAIL error_after: rdata=%h err=%b, required rdata=7777ccbb err=0", rd, e);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] rd, m, exp;
    logic e, me;
    int lat;
    bit to;
    do_op(1, 1'b1, 3'b010, 64'h40, 64'hA5C3_1E0F, 0, rd, e, lat, to);
    model_op(1, 1'b1, 3'b010, 64'h40, 64'hA5C3_1E0F, m, me);
    model_op(1, 1'b0, 3'b010, 64'h40, 64'h0, exp, me);
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 64'h40; req_valid = 3'b010;
    @(posedge clk); #1;
    req_valid = 3'b0;
    lat = 0;
    while (!rsp_valid[1] && lat < 50) begin @(posedge clk); #1; lat++; end
    n_cmp++;
    if (lat != 4) begin
      n_fail++;
      $display("FAIL bp_latency: %0d edges, required 4", lat);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (rsp_valid[1] !== 1'b1 || rdata_of(1) !== exp || rsp_err[1] !== 1'b0 || req_ready[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: vld=%b rdata=%h err=%b rdy=%b, required vld=1 rdata=%h err=0 rdy=0",
                 c, rsp_valid[1], rdata_of(1), rsp_err[1], req_ready[1], exp);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_cmp++;
    if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: vld=%b rdy=%b, required vld=0 rdy=1", rsp_valid[1], req_ready[1]);
    end
  endtask

  task automatic test_random();
    logic [63:0] rd, m, addr, wd;
    logic [2:0] f3;
    logic we, e, me;
    int lat, sz, abits;
    bit to;
    for (int d = 0; d < 3; d++) begin
      abits = (d == 2) ? 13 : 17;
      for (int n = 0; n < 40; n++) begin
        we = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        if (we && $urandom_range(0, 7) != 0) f3[2] = 1'b0;
        sz = 1 << f3[1:0];
        addr = 64'($urandom_range(0, 127));
        if ($urandom_range(0, 3) != 0) addr = addr & ~64'(sz - 1);
        if ($urandom_range(0, 15) == 0) addr = addr | (64'h1 << (abits + $urandom_range(0, 2)));
        wd = {32'($urandom), 32'($urandom)};
        if (d != 2) wd[63:32] = '0;
        do_op(d, we, f3, addr, wd, $urandom_range(0, 2), rd, e, lat, to);
        model_op(d, we, f3, addr, wd, m, me);
        n_cmp++;
        if (to || rd !== m || e !== me || lat != 1 + ws_of(d)) begin
          n_fail++;
          $display("FAIL random[%0d.%0d] we=%b f3=%b addr=%h: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                   d, n, we, f3, addr, rd, e, lat, m, me, 1 + ws_of(d));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd, m;
    logic e, me;
    int lat, n;
    bit to;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 64'h20; req_wdata = 64'hDEADBEEF; req_valid = 3'b010;
    @(posedge clk); #1;
    req_valid = 3'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0 || rsp_err[1] !== 1'b0 || rd1 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: rdy=%b vld=%b err=%b rdata=%h, required 1 0 0 0",
               req_ready[1], rsp_valid[1], rsp_err[1], rd1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1, 1'b0, 3'b010, 64'h20, 64'h0, 0, rd, e, lat, to);
    n_cmp++;
    if (to || rd !== 64'h0 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_drop: rdata=%h err=%b, required rdata=0 err=0", rd, e);
    end
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 64'h24; req_wdata = 64'hCAFEF00D; req_valid = 3'b010;
    @(posedge clk); #1;
    req_valid = 3'b0;
    n = 0;
    while (!rsp_valid[1] && n < 50) begin @(posedge clk); #1; n++; end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rsp_valid[1] !== 1'b0 || n >= 50) begin
      n_fail++;
      $display("FAIL reset_resp_discard: vld=%b wait=%0d, required vld=0", rsp_valid[1], n);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_op(1, 1'b1, 3'b010, 64'h24, 64'hCAFEF00D, m, me);
    do_op(1, 1'b0, 3'b010, 64'h24, 64'h0, 0, rd, e, lat, to);
    n_cmp++;
    if (to || rd !== 64'hCAFEF00D || e !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after_access: rdata=%h err=%b, required rdata=cafef00d err=0", rd, e);
    end
  endtask

  task automatic test_xlen64();
    op_t t[$];
    logic [63:0] rd, m;
    logic e, me;
    int lat;
    bit to;
    t.push_back('{1'b1, 3'b011, 64'h8, 64'h0123456789ABCDEF, 64'h0});
    t.push_back('{1'b0, 3'b011, 64'h8, 64'h0, 64'h0123456789ABCDEF});
    t.push_back('{1'b0, 3'b110, 64'h8, 64'h0, 64'h0000000089ABCDEF});
    t.push_back('{1'b0, 3'b010, 64'h8, 64'h0, 64'hFFFFFFFF89ABCDEF});
    t.push_back('{1'b0, 3'b110, 64'hC, 64'h0, 64'h0000000001234567});
    t.push_back('{1'b0, 3'b001, 64'hE, 64'h0, 64'h0000000000000123});
    foreach (t[i]) begin
      do_op(2, t[i].we, t[i].f3, t[i].addr, t[i].wd, 1, rd, e, lat, to);
      model_op(2, t[i].we, t[i].f3, t[i].addr, t[i].wd, m, me);
      n_cmp++;
      if (to || rd !== t[i].exp || e !== 1'b0 || lat != 3) begin
        n_fail++;
        $display("FAIL x64[%0d]: rdata=%h err=%b lat=%0d to=%0d, required rdata=%h err=0 lat=3",
                 i, rd, e, lat, to, t[i].exp);
      end
    end
  endtask

  initial begin
    test_reset();
    prefill();
    test_basic();
    test_errors();
    test_backpressure();
    test_xlen64();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
